// File: rtl/output_writeback_ctrl.sv
// Drains ARRAY_H rows from the column output shifters, packs each row into one
// wide word and writes the rows to the output buffer, optionally clearing the accumulators.
module output_writeback_ctrl #(
  parameter int ARRAY_W = 4,
  parameter int ARRAY_H = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic                      clear_after,
  input  logic [ARRAY_W*DATA_W-1:0] col_data,
  output logic                      out_en,
  output logic                      acc_clear,
  output logic                      wr_valid,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [ARRAY_W*DATA_W-1:0] wr_data,
  input  logic                      wr_ready,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                dbg_state_o  // FSM state, IDLE encodes as 0
);

  // Write port handshake: a write transfers on every rising edge where wr_valid && wr_ready;
  // once wr_valid is high, wr_addr/wr_data stay stable until that transfer happens.

  localparam int CNT_W = (ARRAY_H > 1) ? $clog2(ARRAY_H) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_FLUSH = 3'd2,
    S_CLEAR = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            row_cnt_q, row_cnt_d;
  logic [ADDR_W-1:0]           base_q, base_d;
  logic                        clear_q, clear_d;
  logic                        wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]           wr_addr_q, wr_addr_d;
  logic [ARRAY_W*DATA_W-1:0]   wr_data_q, wr_data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_cnt_q  <= '0;
      base_q     <= '0;
      clear_q    <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      base_q     <= base_d;
      clear_q    <= clear_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    base_d     = base_q;
    clear_d    = clear_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    out_en     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d    = base_addr;
          clear_d   = clear_after;
          row_cnt_d = '0;
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Shift only when the output register is free or emptying this edge,
        // so a stalled write freezes the shifters and no row is lost.
        out_en = !wr_valid_q || wr_ready;
        if (out_en) begin
          wr_data_d  = col_data;
          wr_addr_d  = base_q + ADDR_W'(row_cnt_q);
          wr_valid_d = 1'b1;
          row_cnt_d  = row_cnt_q + 1'b1;
          if (row_cnt_q == CNT_W'(ARRAY_H - 1)) begin
            state_d = S_FLUSH;
          end
        end else if (wr_valid_q && wr_ready) begin
          wr_valid_d = 1'b0;
        end
      end
      S_FLUSH: begin
        if (wr_valid_q && wr_ready) begin
          wr_valid_d = 1'b0;
          state_d    = clear_q ? S_CLEAR : S_DONE;
        end
      end
      S_CLEAR: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign acc_clear   = (state_q == S_CLEAR);
  assign done        = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_output_writeback_ctrl.sv
// Bench for output_writeback_ctrl: a column shifter model feeds the block, a negedge
// monitor records buffer writes and control pulses, scenario tasks compare against a reference.
module tb_output_writeback_ctrl;

  localparam int AW  = 4;
  localparam int AH  = 4;
  localparam int DW  = 32;
  localparam int ADW = 10;
  localparam int RW  = ADW + AW * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic              start = 1'b0;
  logic [ADW-1:0]    base_addr = '0;
  logic              clear_after = 1'b0;
  logic [AW*DW-1:0]  col_data;
  logic              out_en, acc_clear, wr_valid, busy, done;
  logic [ADW-1:0]    wr_addr;
  logic [AW*DW-1:0]  wr_data;
  logic              wr_ready = 1'b1;
  logic [2:0]        dbg_state;

  output_writeback_ctrl #(.ARRAY_W(AW), .ARRAY_H(AH), .DATA_W(DW), .ADDR_W(ADW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .clear_after(clear_after),
    .col_data(col_data), .out_en(out_en), .acc_clear(acc_clear), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .busy(busy), .done(done),
    .dbg_state_o(dbg_state)
  );

  // ---------------- column shifter model (rotating, clearable) ----------------
  logic [DW-1:0] sh [AW][AH];
  logic [DW-1:0] load_vals [AW][AH];
  logic          load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int c = 0; c < AW; c++)
        for (int r = 0; r < AH; r++) sh[c][r] <= load_vals[c][r];
    end else if (acc_clear) begin
      for (int c = 0; c < AW; c++)
        for (int r = 0; r < AH; r++) sh[c][r] <= '0;
    end else if (out_en) begin
      for (int c = 0; c < AW; c++) begin
        for (int r = 0; r < AH - 1; r++) sh[c][r] <= sh[c][r+1];
        sh[c][AH-1] <= sh[c][0];
      end
    end
  end

  always_comb begin
    col_data = '0;
    for (int c = 0; c < AW; c++) col_data[c*DW +: DW] = sh[c][0];
  end

  // ---------------- monitor ----------------
  logic [RW-1:0]    got_q[$];
  logic [RW-1:0]    exp_q[$];
  int n_out_en, oe_first, oe_last, n_clear, clear_cyc, clear_nwr, n_done, done_cyc, n_stall, viol;
  logic             prev_stall = 1'b0;
  logic [ADW-1:0]   prev_addr;
  logic [AW*DW-1:0] prev_data;
  logic             mon_clr = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      got_q.delete();
      n_out_en = 0; oe_first = 0; oe_last = 0; n_clear = 0; clear_cyc = 0; clear_nwr = 0;
      n_done = 0; done_cyc = 0; n_stall = 0; viol = 0;
      prev_stall = 1'b0;
    end else if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!wr_valid || wr_addr !== prev_addr || wr_data !== prev_data)) viol++;
      if (wr_valid && !wr_ready && out_en) viol++;
      if (out_en && acc_clear) viol++;
      if (wr_valid && wr_ready) got_q.push_back({wr_addr, wr_data});
      if (out_en) begin
        if (n_out_en == 0) oe_first = cyc;
        oe_last = cyc;
        n_out_en++;
      end
      if (acc_clear) begin
        n_clear++;
        clear_cyc = cyc;
        clear_nwr = got_q.size();
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      prev_stall = wr_valid && !wr_ready;
      if (prev_stall) n_stall++;
      prev_addr = wr_addr;
      prev_data = wr_data;
    end
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  int start_cyc = 0;

  // ---------------- drivers ----------------
  task automatic load_random();
    for (int c = 0; c < AW; c++)
      for (int r = 0; r < AH; r++) load_vals[c][r] = $urandom;
  endtask

  // Reference: row r of the drain lands at (base + r) mod 2^ADW, columns packed low-first.
  task automatic build_expected(input logic [ADW-1:0] base);
    exp_q.delete();
    for (int r = 0; r < AH; r++) begin
      logic [AW*DW-1:0] row;
      logic [ADW-1:0]   addr;
      row = '0;
      for (int c = 0; c < AW; c++) row[c*DW +: DW] = load_vals[c][r];
      addr = ADW'((int'(base) + r) % (1 << ADW));
      exp_q.push_back({addr, row});
    end
  endtask

  task automatic arm(input logic [ADW-1:0] base);
    build_expected(base);
    load_req = 1'b1;
    mon_clr  = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    mon_clr  = 1'b0;
  endtask

  function automatic logic ready_for(input int mode, input int k);
    logic [5:0] pat;
    pat = 6'b101001;  // cycle k uses bit k%6: 1,0,0,1,0,1
    case (mode)
      1:       return pat[k % 6];
      2:       return logic'($urandom_range(0, 1));
      default: return 1'b1;
    endcase
  endfunction

  // Runs one drain and checks the write stream against the expected queue.
  task automatic run_drain(input string name, input logic [ADW-1:0] base, input logic clr,
                           input int mode, input bit extra_start);
    arm(base);
    base_addr   = base;
    clear_after = clr;
    start       = 1'b1;
    start_cyc   = cyc;
    wr_ready    = ready_for(mode, 0);
    for (int k = 1; k < 300; k++) begin
      @(posedge clk); #1;
      start     = extra_start && (k == 2);
      base_addr = $urandom;
      wr_ready  = ready_for(mode, k);
      if (n_done > 0) break;
    end
    start    = 1'b0;
    wr_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL %s write_count: got %0d expected %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s write[%0d]: got %0h expected %0h", name, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 8;
    if (wr_valid  !== 1'b0) begin failures++; $display("FAIL reset wr_valid: got %b expected 0", wr_valid); end
    if (out_en    !== 1'b0) begin failures++; $display("FAIL reset out_en: got %b expected 0", out_en); end
    if (acc_clear !== 1'b0) begin failures++; $display("FAIL reset acc_clear: got %b expected 0", acc_clear); end
    if (busy      !== 1'b0) begin failures++; $display("FAIL reset busy: got %b expected 0", busy); end
    if (done      !== 1'b0) begin failures++; $display("FAIL reset done: got %b expected 0", done); end
    if (wr_addr   !== '0)   begin failures++; $display("FAIL reset wr_addr: got %0h expected 0", wr_addr); end
    if (wr_data   !== '0)   begin failures++; $display("FAIL reset wr_data: got %0h expected 0", wr_data); end
    if (dbg_state !== 3'd0) begin failures++; $display("FAIL reset state: got %0d expected 0", dbg_state); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int bad;
    for (int c = 0; c < AW; c++)
      for (int r = 0; r < AH; r++) load_vals[c][r] = DW'(16 * r + c);
    run_drain("basic", 10'h010, 1'b0, 0, 1'b0);
    checks += 5;
    if (n_out_en !== AH) begin failures++; $display("FAIL basic out_en_cycles: got %0d expected %0d", n_out_en, AH); end
    if (oe_last - oe_first !== AH - 1) begin failures++; $display("FAIL basic out_en_consecutive: got span %0d expected %0d", oe_last - oe_first, AH - 1); end
    if (n_clear !== 0) begin failures++; $display("FAIL basic acc_clear_count: got %0d expected 0", n_clear); end
    if (n_done !== 1) begin failures++; $display("FAIL basic done_count: got %0d expected 1", n_done); end
    if (done_cyc - start_cyc !== AH + 2) begin failures++; $display("FAIL basic done_latency: got %0d expected %0d", done_cyc - start_cyc, AH + 2); end
    bad = 0;
    for (int c = 0; c < AW; c++)
      for (int r = 0; r < AH; r++) if (sh[c][r] !== load_vals[c][r]) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL basic shifters_kept: got %0d changed words expected 0", bad); end
  endtask

  task automatic test_backpressure();
    for (int m = 1; m <= 2; m++) begin
      load_random();
      run_drain(m == 1 ? "bp_pattern" : "bp_random", ADW'($urandom), 1'b0, m, 1'b0);
      checks += 4;
      if (viol !== 0) begin failures++; $display("FAIL bp%0d protocol_violations: got %0d expected 0", m, viol); end
      if (n_stall == 0) begin failures++; $display("FAIL bp%0d stalls_seen: got 0 expected >0", m); end
      if (n_out_en !== AH) begin failures++; $display("FAIL bp%0d out_en_cycles: got %0d expected %0d", m, n_out_en, AH); end
      if (n_done !== 1) begin failures++; $display("FAIL bp%0d done_count: got %0d expected 1", m, n_done); end
    end
  endtask

  task automatic test_clear_after();
    int nz;
    load_random();
    run_drain("clear", ADW'($urandom), 1'b1, 0, 1'b0);
    checks += 5;
    if (n_clear !== 1) begin failures++; $display("FAIL clear pulse_count: got %0d expected 1", n_clear); end
    if (clear_nwr !== AH) begin failures++; $display("FAIL clear writes_before_clear: got %0d expected %0d", clear_nwr, AH); end
    if (!(clear_cyc < done_cyc)) begin failures++; $display("FAIL clear order: got clear@%0d done@%0d expected clear first", clear_cyc, done_cyc); end
    if (done_cyc - start_cyc !== AH + 3) begin failures++; $display("FAIL clear done_latency: got %0d expected %0d", done_cyc - start_cyc, AH + 3); end
    if (viol !== 0) begin failures++; $display("FAIL clear protocol_violations: got %0d expected 0", viol); end
    nz = 0;
    for (int c = 0; c < AW; c++)
      for (int r = 0; r < AH; r++) if (sh[c][r] !== '0) nz++;
    checks++;
    if (nz != 0) begin failures++; $display("FAIL clear shifters_zero: got %0d nonzero words expected 0", nz); end
  endtask

  task automatic test_wrap();
    logic [ADW-1:0] want [AH];
    want[0] = 10'h3FE; want[1] = 10'h3FF; want[2] = 10'h000; want[3] = 10'h001;
    load_random();
    run_drain("wrap", 10'h3FE, 1'b0, 2, 1'b0);
    for (int i = 0; i < AH && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i][RW-1 -: ADW] !== want[i]) begin
        failures++;
        $display("FAIL wrap addr[%0d]: got %0h expected %0h", i, got_q[i][RW-1 -: ADW], want[i]);
      end
    end
  endtask

  task automatic test_start_busy();
    load_random();
    run_drain("start_busy", ADW'($urandom), 1'b0, 0, 1'b1);
    checks += 2;
    if (n_done !== 1) begin failures++; $display("FAIL start_busy done_count: got %0d expected 1", n_done); end
    if (n_out_en !== AH) begin failures++; $display("FAIL start_busy out_en_cycles: got %0d expected %0d", n_out_en, AH); end
  endtask

  task automatic test_reset_mid();
    int waited;
    load_random();
    arm(ADW'($urandom));
    start    = 1'b1;
    wr_ready = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    waited = 0;
    while (got_q.size() < 2 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (got_q.size() < 2) begin failures++; $display("FAIL rst_mid two_rows: got %0d expected 2", got_q.size()); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks += 5;
    if (dbg_state !== 3'd0) begin failures++; $display("FAIL rst_mid state: got %0d expected 0", dbg_state); end
    if (wr_valid !== 1'b0) begin failures++; $display("FAIL rst_mid wr_valid: got %b expected 0", wr_valid); end
    if (out_en !== 1'b0) begin failures++; $display("FAIL rst_mid out_en: got %b expected 0", out_en); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL rst_mid done: got %b expected 0", done); end
    rst = 1'b0;
    @(posedge clk); #1;
    load_random();
    run_drain("rst_mid_restart", ADW'($urandom), 1'b0, 0, 1'b0);
    checks++;
    if (n_done !== 1) begin failures++; $display("FAIL rst_mid restart_done: got %0d expected 1", n_done); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      logic clr;
      clr = logic'($urandom_range(0, 1));
      load_random();
      run_drain("random", ADW'($urandom), clr, 2, 1'b0);
      checks += 2;
      if (n_clear !== (clr ? 1 : 0)) begin failures++; $display("FAIL random clear_count: got %0d expected %0d", n_clear, clr ? 1 : 0); end
      if (viol !== 0) begin failures++; $display("FAIL random protocol_violations: got %0d expected 0", viol); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_clear_after();
    test_wrap();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
